poly_note_allocator: RTL and testbench
======================================

// Module: poly_note_allocator
// PURPOSE
//  Polyphonic successor to the single-note switch decoder. Scans NUM_KEYS switch inputs and maps each key
//  to a MIDI note in major-scale or chromatic mode. Allocates held keys to NUM_VOICES synth voices and
//  emits note-on/off events over a valid/ready stream. Sits between the board switches and the voice/DDS bank.
// PARAMETERS
//  NUM_KEYS    16  number of key switches scanned (>=1)
//  NUM_VOICES  4   number of voice slots (>=1)
//  BASE_NOTE   60  MIDI note of key 0 (C4)
//  NOTE_W      8   note field width; valid notes are 0..127
// PORTS
//  clk_in            in   1                        system clock, single domain
//  rst_n_in          in   1                        reset, asynchronous, active-low
//  sw_in             in   NUM_KEYS                 raw key switches, asynchronous to clk_in
//  mode_in           in   1                        0=major scale, 1=chromatic; asynchronous
//  evt_valid_out     out  1                        event available
//  evt_ready_in      in   1                        consumer accepts event
//  evt_on_out        out  1                        1=note-on, 0=note-off
//  evt_note_out      out  NOTE_W                   event note
//  evt_voice_out     out  $clog2(NUM_VOICES)       event voice slot
//  voice_active_out  out  NUM_VOICES               per-voice busy flag
//  voice_note_out    out  NUM_VOICES*NOTE_W        per-voice note; voice v is at [v*NOTE_W +: NOTE_W]
// BEHAVIOUR
//  Reset: all outputs 0, key_held 0, mode_held 0, idx 0, state SCAN. Applies asynchronously mid-operation;
//   evt_valid_out drops immediately. No event survives reset.
//  Synchronisation: sw_in and mode_in each pass through a 2-flop synchroniser (reset 0) before use.
//  Note map, key k:
//   - Chromatic: BASE_NOTE + k.
//   - Major: BASE_NOTE + 12*(k/7) + {0,2,4,5,7,9,11}[k%7].
//   - Computed at >=NOTE_W+4 bits. If the result is >127, key k is unmappable and never generates events.
//  FSM SCAN (one key per cycle, idx 0..NUM_KEYS-1, wraps to 0):
//   - If mode_sync != mode_held, go FLUSH. This has priority over key checks.
//   - Key pressed (sync=1, held=0), mappable, free voice exists: load on-event; voice = lowest-index free
//     slot; go EMIT.
//   - Key pressed, no free voice or unmappable: set key_held[idx]=1, no event, advance.
//     The key stays voiceless until released and re-pressed.
//   - Key released (sync=0, held=1) and it owns a voice: load off-event for that voice; go EMIT.
//   - Key released and it owns no voice: clear key_held[idx], no event, advance.
//   - Otherwise advance.
//  EMIT:
//   - evt_valid_out=1; payload is stable until the handshake.
//   - On evt_valid_out & evt_ready_in: commit key_held[idx] and the voice table (active/note/owner key),
//     advance idx, return to SCAN.
//   - Key changes while in EMIT are picked up on a later scan pass.
//   - voice_*_out change only in the cycle after a handshake.
//  FLUSH:
//   - Walk voices 0..NUM_VOICES-1. Each active voice emits an off-event, held until accepted, then freed.
//   - After the last voice: clear all key_held, mode_held <= mode_sync, idx <= 0, go SCAN.
//   - Held keys are then re-pressed under the new mapping.
//  Latency: a key change is seen at most NUM_KEYS cycles after sync. The event is valid 1 cycle later.
//   Max one event per 2 cycles.
//  Simultaneous press/release of different keys: serviced in scan order. The same key cannot both press
//   and release in one evaluation.
//  Voice owner key index is internal state and is cleared on free.
// TESTING
//  1 major, ready=1, sw_in=0x0001 -> one on-event note 60 voice 0; voice_active_out=0001;
//    release -> off-event note 60 voice 0; active=0000.
//  2 major, sw_in=0x0080 -> on note 72; sw_in bit 8 -> note 74;
//    chromatic sw_in bit 7 -> note 67.
//  3 keys 0..4 pressed together -> on-events 60,62,64,65 on voices 0..3, none for key 4;
//    release key 0 -> off voice 0; key 4 still voiceless.
//  4 ready=0 for 20 cycles during a pending on-event -> evt_valid_out stays 1 and the payload is stable;
//    exactly one handshake when ready=1.
//  5 keys 0,2 held in major, flip mode_in=1 -> off 60 (v0), off 64 (v1), then on 60 (v0), on 62 (v1).
//  6 BASE_NOTE=120 chromatic, key 15 pressed -> no event. Assert rst_n_in mid-EMIT -> valid drops
//    asynchronously, all outputs 0.

Source files
------------

// File: rtl/poly_note_allocator.sv
`default_nettype none
// ============================================================================
// Module      : poly_note_allocator
// Description : Scans NUM_KEYS key switches one key per clock, maps each key
//               to a MIDI note (major scale or chromatic), assigns held keys
//               to NUM_VOICES voice slots and streams note-on/off events over
//               a valid/ready handshake.
// Ports       : clk_in, rst_n_in       clock, async active-low reset
//               sw_in, mode_in         raw async key switches / scale mode
//               evt_*                  event stream (valid/ready, on, note, voice)
//               voice_active_out       per-voice busy flags
//               voice_note_out         per-voice notes, voice v at [v*NOTE_W +: NOTE_W]
// Revision    : 1.0 - initial release
// ============================================================================
module poly_note_allocator #(
    parameter int NUM_KEYS   = 16,
    parameter int NUM_VOICES = 4,
    parameter int BASE_NOTE  = 60,
    parameter int NOTE_W     = 8,
    localparam int VW = (NUM_VOICES > 1) ? $clog2(NUM_VOICES) : 1,
    localparam int KW = (NUM_KEYS > 1) ? $clog2(NUM_KEYS) : 1
) (
    input  logic                         clk_in,
    input  logic                         rst_n_in,
    input  logic [NUM_KEYS-1:0]          sw_in,
    input  logic                         mode_in,
    output logic                         evt_valid_out,
    input  logic                         evt_ready_in,
    output logic                         evt_on_out,
    output logic [NOTE_W-1:0]            evt_note_out,
    output logic [VW-1:0]                evt_voice_out,
    output logic [NUM_VOICES-1:0]        voice_active_out,
    output logic [NUM_VOICES*NOTE_W-1:0] voice_note_out
);

    localparam logic [1:0] SCAN  = 2'd0;  // step through keys
    localparam logic [1:0] EMIT  = 2'd1;  // scan-generated event pending
    localparam logic [1:0] FLUSH = 2'd2;  // walk voices after a mode change
    localparam logic [1:0] FEMIT = 2'd3;  // flush off-event pending

    logic [1:0]            state, state_nxt;
    logic [NUM_KEYS-1:0]   sw_meta, sw_sync, key_held;
    logic                  mode_meta, mode_sync, mode_held;
    logic [KW-1:0]         idx;
    logic [VW-1:0]         fidx;
    logic [NUM_VOICES-1:0] voice_active;
    logic [NOTE_W-1:0]     voice_note  [NUM_VOICES];
    logic [KW-1:0]         voice_owner [NUM_VOICES];
    logic                  evt_on;
    logic [NOTE_W-1:0]     evt_note;
    logic [VW-1:0]         evt_voice;

    // Two-flop synchronisers for the asynchronous switch and mode inputs.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            sw_meta   <= '0;
            sw_sync   <= '0;
            mode_meta <= 1'b0;
            mode_sync <= 1'b0;
        end else begin
            sw_meta   <= sw_in;
            sw_sync   <= sw_meta;
            mode_meta <= mode_in;
            mode_sync <= mode_meta;
        end
    end

    // Note map of the key under scan, computed wide so out-of-range notes
    // are detected rather than wrapped.
    logic [31:0] k32, scale_off, key_wide;
    logic        mappable;
    always_comb begin
        k32       = 32'(idx);
        scale_off = 32'd0;
        case (k32 % 32'd7)
            32'd1:   scale_off = 32'd2;
            32'd2:   scale_off = 32'd4;
            32'd3:   scale_off = 32'd5;
            32'd4:   scale_off = 32'd7;
            32'd5:   scale_off = 32'd9;
            32'd6:   scale_off = 32'd11;
            default: scale_off = 32'd0;
        endcase
        if (mode_held)
            key_wide = 32'(BASE_NOTE) + k32;
        else
            key_wide = 32'(BASE_NOTE) + 32'd12 * (k32 / 32'd7) + scale_off;
        mappable = (key_wide <= 32'd127);
    end

    // Lowest free voice, and the voice (if any) owned by the scanned key.
    logic          free_found, owned;
    logic [VW-1:0] free_v, own_v;
    always_comb begin
        free_found = 1'b0;
        free_v     = '0;
        owned      = 1'b0;
        own_v      = '0;
        for (int v = NUM_VOICES - 1; v >= 0; v--) begin
            if (!voice_active[v]) begin
                free_found = 1'b1;
                free_v     = VW'(v);
            end
            if (voice_active[v] && (voice_owner[v] == idx)) begin
                owned = 1'b1;
                own_v = VW'(v);
            end
        end
    end

    logic          pressed, released, mode_change, handshake, last_voice;
    logic          start_on, start_off;
    logic [KW-1:0] idx_next;
    assign pressed     = sw_sync[idx] && !key_held[idx];
    assign released    = !sw_sync[idx] && key_held[idx];
    assign mode_change = (mode_sync != mode_held);
    assign handshake   = evt_valid_out && evt_ready_in;
    assign last_voice  = (fidx == VW'(NUM_VOICES - 1));
    assign start_on    = pressed && mappable && free_found;
    assign start_off   = released && owned;
    assign idx_next    = (idx == KW'(NUM_KEYS - 1)) ? '0 : idx + 1'b1;

    // State register
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) state <= SCAN;
        else           state <= state_nxt;
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            SCAN:    if (mode_change)            state_nxt = FLUSH;
                     else if (start_on || start_off) state_nxt = EMIT;
            EMIT:    if (handshake)              state_nxt = SCAN;
            FLUSH:   if (voice_active[fidx])     state_nxt = FEMIT;
                     else if (last_voice)        state_nxt = SCAN;
            FEMIT:   if (handshake)              state_nxt = last_voice ? SCAN : FLUSH;
            default:                             state_nxt = SCAN;
        endcase
    end

    // Datapath: key bookkeeping, event payload and voice table.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            key_held     <= '0;
            mode_held    <= 1'b0;
            idx          <= '0;
            fidx         <= '0;
            voice_active <= '0;
            evt_on       <= 1'b0;
            evt_note     <= '0;
            evt_voice    <= '0;
            for (int v = 0; v < NUM_VOICES; v++) begin
                voice_note[v]  <= '0;
                voice_owner[v] <= '0;
            end
        end else begin
            case (state)
                SCAN: begin
                    if (mode_change) begin
                        fidx <= '0;
                    end else if (start_on) begin
                        evt_on    <= 1'b1;
                        evt_note  <= key_wide[NOTE_W-1:0];
                        evt_voice <= free_v;
                    end else if (start_off) begin
                        evt_on    <= 1'b0;
                        evt_note  <= voice_note[own_v];
                        evt_voice <= own_v;
                    end else begin
                        // Voiceless presses are latched so the key stays
                        // silent until it is released and pressed again.
                        if (pressed)       key_held[idx] <= 1'b1;
                        else if (released) key_held[idx] <= 1'b0;
                        idx <= idx_next;
                    end
                end
                EMIT: begin
                    if (handshake) begin
                        key_held[idx]           <= evt_on;
                        voice_active[evt_voice] <= evt_on;
                        voice_note[evt_voice]   <= evt_on ? evt_note : '0;
                        voice_owner[evt_voice]  <= evt_on ? idx : '0;
                        idx                     <= idx_next;
                    end
                end
                FLUSH: begin
                    if (voice_active[fidx]) begin
                        evt_on    <= 1'b0;
                        evt_note  <= voice_note[fidx];
                        evt_voice <= fidx;
                    end else if (last_voice) begin
                        key_held  <= '0;
                        mode_held <= mode_sync;
                        idx       <= '0;
                    end else begin
                        fidx <= fidx + 1'b1;
                    end
                end
                FEMIT: begin
                    if (handshake) begin
                        voice_active[fidx] <= 1'b0;
                        voice_note[fidx]   <= '0;
                        voice_owner[fidx]  <= '0;
                        if (last_voice) begin
                            key_held  <= '0;
                            mode_held <= mode_sync;
                            idx       <= '0;
                        end else begin
                            fidx <= fidx + 1'b1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    // Output logic: valid decodes straight from state so reset drops it
    // immediately; payload reads as zero whenever no event is offered.
    always_comb begin
        evt_valid_out = (state == EMIT) || (state == FEMIT);
        evt_on_out    = evt_valid_out && evt_on;
        evt_note_out  = evt_valid_out ? evt_note : '0;
        evt_voice_out = evt_valid_out ? evt_voice : '0;
    end

    assign voice_active_out = voice_active;

    for (genvar v = 0; v < NUM_VOICES; v++) begin : g_voice_out
        assign voice_note_out[v*NOTE_W +: NOTE_W] = voice_note[v];
    end

endmodule
`default_nettype wire

// File: tb/tb_poly_note_allocator.sv
`default_nettype none
// ============================================================================
// Module      : tb_poly_note_allocator
// Description : Directed self-checking bench for poly_note_allocator. One
//               instance with default parameters, a second with BASE_NOTE=120
//               for the unmappable-note boundary and mid-event reset.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_poly_note_allocator;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [15:0] sw, sw2;
    logic        mode, mode2, ready, ready2;
    logic        valid, on, valid2, on2;
    logic [7:0]  note, note2;
    logic [1:0]  voice, voice2;
    logic [3:0]  vact, vact2;
    logic [31:0] vnote, vnote2;

    int passed = 0;
    int total  = 0;
    int fails  = 0;

    always #5 clk = ~clk;

    poly_note_allocator #(.NUM_KEYS(16), .NUM_VOICES(4), .BASE_NOTE(60), .NOTE_W(8)) dut (
        .clk_in(clk), .rst_n_in(rst_n), .sw_in(sw), .mode_in(mode),
        .evt_valid_out(valid), .evt_ready_in(ready), .evt_on_out(on),
        .evt_note_out(note), .evt_voice_out(voice),
        .voice_active_out(vact), .voice_note_out(vnote)
    );

    poly_note_allocator #(.NUM_KEYS(16), .NUM_VOICES(4), .BASE_NOTE(120), .NOTE_W(8)) dut2 (
        .clk_in(clk), .rst_n_in(rst_n), .sw_in(sw2), .mode_in(mode2),
        .evt_valid_out(valid2), .evt_ready_in(ready2), .evt_on_out(on2),
        .evt_note_out(note2), .evt_voice_out(voice2),
        .voice_active_out(vact2), .voice_note_out(vnote2)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            fails++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Wait (bounded) for an event on dut, check it, let it handshake.
    task automatic get_evt(input string tag, input logic e_on, input logic [7:0] e_note,
                           input logic [1:0] e_voice);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!valid && n < 80);
        check({tag, "_valid"}, 32'(valid), 32'd1);
        check({tag, "_on"},    32'(on),    32'(e_on));
        check({tag, "_note"},  32'(note),  32'(e_note));
        check({tag, "_voice"}, 32'(voice), 32'(e_voice));
        @(posedge clk);
        #1;
    endtask

    task automatic get_evt2(input string tag, input logic e_on, input logic [7:0] e_note,
                            input logic [1:0] e_voice);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!valid2 && n < 80);
        check({tag, "_valid"}, 32'(valid2), 32'd1);
        check({tag, "_on"},    32'(on2),    32'(e_on));
        check({tag, "_note"},  32'(note2),  32'(e_note));
        check({tag, "_voice"}, 32'(voice2), 32'(e_voice));
        @(posedge clk);
        #1;
    endtask

    task automatic no_evt(input string tag, input int cycles);
        int cnt = 0;
        repeat (cycles) begin
            @(negedge clk);
            if (valid) cnt++;
        end
        check(tag, 32'(cnt), 32'd0);
    endtask

    task automatic no_evt2(input string tag, input int cycles);
        int cnt = 0;
        repeat (cycles) begin
            @(negedge clk);
            if (valid2) cnt++;
        end
        check(tag, 32'(cnt), 32'd0);
    endtask

    initial begin
        int          n;
        int          hs;
        logic        stable;
        logic [7:0]  snap_note;
        logic [1:0]  snap_voice;
        logic        snap_on;

        rst_n = 1'b0; sw = '0; sw2 = '0; mode = 1'b0; mode2 = 1'b1;
        ready = 1'b1; ready2 = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_valid", 32'(valid), 32'd0);
        check("rst_act",   32'(vact),  32'd0);
        check("rst_vnote", vnote,      32'd0);
        check("rst_note",  32'(note),  32'd0);
        rst_n = 1'b1;

        // 1: single key in major mode
        @(negedge clk);
        sw = 16'h0001;
        get_evt("t1_on", 1'b1, 8'd60, 2'd0);
        check("t1_act",   32'(vact),   32'h1);
        check("t1_vnote", vnote,       32'd60);
        sw = 16'h0000;
        get_evt("t1_off", 1'b0, 8'd60, 2'd0);
        check("t1_act_off", 32'(vact), 32'h0);
        check("t1_vnote_off", vnote,   32'd0);

        // 2: octave wrap in major, then chromatic
        sw = 16'h0080;
        get_evt("t2_k7_on", 1'b1, 8'd72, 2'd0);
        sw = 16'h0000;
        get_evt("t2_k7_off", 1'b0, 8'd72, 2'd0);
        sw = 16'h0100;
        get_evt("t2_k8_on", 1'b1, 8'd74, 2'd0);
        sw = 16'h0000;
        get_evt("t2_k8_off", 1'b0, 8'd74, 2'd0);
        mode = 1'b1;
        repeat (10) @(negedge clk);
        sw = 16'h0080;
        get_evt("t2_chr_on", 1'b1, 8'd67, 2'd0);
        sw = 16'h0000;
        get_evt("t2_chr_off", 1'b0, 8'd67, 2'd0);

        // 3: five keys, four voices; the mode flip restarts the scan at key 0
        mode = 1'b0;
        sw   = 16'h001F;
        get_evt("t3_k0", 1'b1, 8'd60, 2'd0);
        get_evt("t3_k1", 1'b1, 8'd62, 2'd1);
        get_evt("t3_k2", 1'b1, 8'd64, 2'd2);
        get_evt("t3_k3", 1'b1, 8'd65, 2'd3);
        no_evt("t3_k4_none", 40);
        check("t3_act_full", 32'(vact), 32'hF);
        sw = 16'h001E;
        get_evt("t3_k0_off", 1'b0, 8'd60, 2'd0);
        no_evt("t3_k4_still_none", 40);
        check("t3_act_after", 32'(vact), 32'hE);

        // 4: back-pressure holds the event and payload steady
        ready = 1'b0;
        sw    = 16'h003E;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!valid && n < 80);
        check("t4_valid", 32'(valid), 32'd1);
        check("t4_on",    32'(on),    32'd1);
        check("t4_note",  32'(note),  32'd69);
        check("t4_voice", 32'(voice), 32'd0);
        snap_on = on; snap_note = note; snap_voice = voice;
        stable = 1'b1;
        repeat (20) begin
            @(negedge clk);
            if (!valid || on !== snap_on || note !== snap_note || voice !== snap_voice
                || vact !== 4'hE)
                stable = 1'b0;
        end
        check("t4_hold_stable", 32'(stable), 32'd1);
        ready = 1'b1;
        hs = 0;
        repeat (40) begin
            if (valid) hs++;
            @(negedge clk);
        end
        check("t4_one_handshake", 32'(hs), 32'd1);
        check("t4_act", 32'(vact), 32'hF);

        // 5: mode flip flushes voices in voice order, then re-presses
        mode = 1'b1;
        sw   = 16'h0000;
        get_evt("t5_fl_v0", 1'b0, 8'd69, 2'd0);
        get_evt("t5_fl_v1", 1'b0, 8'd62, 2'd1);
        get_evt("t5_fl_v2", 1'b0, 8'd64, 2'd2);
        get_evt("t5_fl_v3", 1'b0, 8'd65, 2'd3);
        check("t5_act_clear", 32'(vact), 32'h0);
        mode = 1'b0;
        sw   = 16'h0005;
        get_evt("t5_maj_k0", 1'b1, 8'd60, 2'd0);
        get_evt("t5_maj_k2", 1'b1, 8'd64, 2'd1);
        mode = 1'b1;
        get_evt("t5_off_v0", 1'b0, 8'd60, 2'd0);
        get_evt("t5_off_v1", 1'b0, 8'd64, 2'd1);
        get_evt("t5_chr_k0", 1'b1, 8'd60, 2'd0);
        get_evt("t5_chr_k2", 1'b1, 8'd62, 2'd1);
        check("t5_vnote", vnote, 32'h0000_3E3C);

        // 6: BASE_NOTE=120 chromatic, note-127 boundary, async reset mid-event
        sw2 = 16'h8000;
        no_evt2("t6_k15_none", 40);
        sw2 = 16'h8080;
        get_evt2("t6_k7_127", 1'b1, 8'd127, 2'd0);
        sw2 = 16'h8180;
        no_evt2("t6_k8_none", 40);
        ready2 = 1'b0;
        sw2    = 16'h81C0;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!valid2 && n < 80);
        check("t6_k6_valid", 32'(valid2), 32'd1);
        check("t6_k6_note",  32'(note2),  32'd126);
        check("t6_k6_voice", 32'(voice2), 32'd1);
        check("t6_act_pre",  32'(vact2),  32'h1);
        #2;
        rst_n = 1'b0;
        #1;
        check("t6_rst_valid", 32'(valid2), 32'd0);
        check("t6_rst_on",    32'(on2),    32'd0);
        check("t6_rst_note",  32'(note2),  32'd0);
        check("t6_rst_voice", 32'(voice2), 32'd0);
        check("t6_rst_act",   32'(vact2),  32'd0);
        check("t6_rst_vnote", vnote2,      32'd0);
        check("t6_rst_dut1_act",   32'(vact),  32'd0);
        check("t6_rst_dut1_vnote", vnote,      32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
`default_nettype wire
